// File: rtl/sm_pkg.sv
// Signed-magnitude types and helpers shared by the subtractor pipeline and
// the pipelined adder variant.
`ifndef N
`define N 16
`endif
`ifndef F
`define F 8
`endif

package sm_pkg;

    typedef logic [`N-1:0] sm_t;

    localparam logic [`N-2:0] SM_MAG_MAX  = {(`N-1){1'b1}};
    localparam sm_t           SM_NEG_ZERO = {1'b1, {(`N-1){1'b0}}};

    function automatic sm_t sm_negate(input sm_t x);
        return {~x[`N-1], x[`N-2:0]};
    endfunction

    function automatic sm_t sm_norm_zero(input sm_t x);
        return (x == SM_NEG_ZERO) ? '0 : x;
    endfunction

endpackage

// File: rtl/sm_mag_unit.sv
// Combinational magnitude add/subtract with saturation and -0 suppression.
module sm_mag_unit
    import sm_pkg::*;
#(
    parameter int unsigned N = `N
) (
    input  logic         sub,
    input  logic         a_ge_b,
    input  logic         a_sign,
    input  logic         b_sign,
    input  logic [N-2:0] a_mag,
    input  logic [N-2:0] b_mag,
    output logic [N-1:0] c,
    output logic         ovf
);

    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sign;

    always_comb begin
        sum  = {1'b0, a_mag} + {1'b0, b_mag};
        mag  = '0;
        sign = 1'b0;
        ovf  = 1'b0;
        if (!sub) begin
            sign = a_sign;
            // A carry into the sign position means the magnitude no longer fits.
            if (sum[N-1]) begin
                mag = SM_MAG_MAX;
                ovf = 1'b1;
            end else begin
                mag = sum[N-2:0];
            end
        end else if (a_ge_b) begin
            mag  = a_mag - b_mag;
            sign = a_sign;
        end else begin
            mag  = b_mag - a_mag;
            sign = b_sign;
        end
        c = {sign && (mag != '0), mag};
    end

endmodule

// File: rtl/sm_sub_pipe.sv
// Two-stage signed-magnitude subtractor c = a - b with valid/ready handshake,
// saturation and negative-zero normalization.
module sm_sub_pipe
    import sm_pkg::*;
#(
    parameter int unsigned N = `N,
    parameter int unsigned F = `F
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    if (F > N - 1) begin : g_frac_check
        $error("sm_sub_pipe: F exceeds magnitude width");
    end

    logic         s1_v_q, s1_v_d;
    logic         s1_a_sign_q, s1_a_sign_d;
    logic         s1_b_sign_q, s1_b_sign_d;
    logic         s1_a_ge_b_q, s1_a_ge_b_d;
    logic         s1_sub_q, s1_sub_d;
    logic [N-2:0] s1_a_mag_q, s1_a_mag_d;
    logic [N-2:0] s1_b_mag_q, s1_b_mag_d;
    logic         s2_v_q, s2_v_d;
    logic [N-1:0] c_q, c_d;
    logic         ovf_q, ovf_d;

    logic         adv;
    logic         in_fire;
    sm_t          a_n;
    sm_t          b_e;
    logic [N-1:0] unit_c;
    logic         unit_ovf;

    sm_mag_unit #(.N(N)) u_mag (
        .sub    (s1_sub_q),
        .a_ge_b (s1_a_ge_b_q),
        .a_sign (s1_a_sign_q),
        .b_sign (s1_b_sign_q),
        .a_mag  (s1_a_mag_q),
        .b_mag  (s1_b_mag_q),
        .c      (unit_c),
        .ovf    (unit_ovf)
    );

    always_comb begin
        adv      = !s2_v_q || out_ready;
        in_ready = !rst && (!s1_v_q || adv);
        in_fire  = in_valid && in_ready;
        // Both operands are cleaned of -0 so the compare and op select see +0.
        a_n      = sm_norm_zero(a);
        b_e      = sm_norm_zero(sm_negate(b));

        s1_v_d      = s1_v_q;
        s1_a_sign_d = s1_a_sign_q;
        s1_b_sign_d = s1_b_sign_q;
        s1_a_ge_b_d = s1_a_ge_b_q;
        s1_sub_d    = s1_sub_q;
        s1_a_mag_d  = s1_a_mag_q;
        s1_b_mag_d  = s1_b_mag_q;
        s2_v_d      = s2_v_q;
        c_d         = c_q;
        ovf_d       = ovf_q;

        if (in_fire) begin
            s1_v_d      = 1'b1;
            s1_a_sign_d = a_n[N-1];
            s1_b_sign_d = b_e[N-1];
            s1_a_ge_b_d = a_n[N-2:0] >= b_e[N-2:0];
            s1_sub_d    = a_n[N-1] ^ b_e[N-1];
            s1_a_mag_d  = a_n[N-2:0];
            s1_b_mag_d  = b_e[N-2:0];
        end else if (adv) begin
            s1_v_d = 1'b0;
        end

        if (adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                c_d   = unit_c;
                ovf_d = unit_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_a_sign_q <= 1'b0;
            s1_b_sign_q <= 1'b0;
            s1_a_ge_b_q <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_a_mag_q  <= '0;
            s1_b_mag_q  <= '0;
            s2_v_q      <= 1'b0;
            c_q         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_a_sign_q <= s1_a_sign_d;
            s1_b_sign_q <= s1_b_sign_d;
            s1_a_ge_b_q <= s1_a_ge_b_d;
            s1_sub_q    <= s1_sub_d;
            s1_a_mag_q  <= s1_a_mag_d;
            s1_b_mag_q  <= s1_b_mag_d;
            s2_v_q      <= s2_v_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = s2_v_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/sm_sub_pipe.md
# sm_sub_pipe

Pipelined signed-magnitude subtractor computing c = a − b on `N`-bit operands with `F` fraction bits. It is the subtracting counterpart of the combinational signed-magnitude adder in the MLP datapath, used for error terms and bias removal. It adds a 2-stage pipeline, valid/ready flow control, saturation with an overflow flag, and negative-zero normalization.

## Interface
- N, default `N: total width; bit N-1 is the sign, bits N-2:0 the magnitude.
- F, default `F: fraction bits. Used only for documentation and test scaling; arithmetic is format-agnostic.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  stage 1 can accept; a transfer happens when in_valid && in_ready.
- a  in  N  minuend, signed magnitude.
- b  in  N  subtrahend, signed magnitude.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts; a transfer happens when out_valid && out_ready.
- c  out  N  difference, signed magnitude, never −0.
- ovf  out  1  result magnitude saturated; qualified by out_valid.

## Operation
- Effective subtrahend: sign flipped, b' = {~b[N-1], b[N-2:0]}.
- Input −0 (sign=1, magnitude=0) is treated as +0 before any comparison.
- Same effective sign:
  - magnitude = a_mag + b_mag, computed N bits wide.
  - Carry into bit N-1 sets ovf=1 and clamps the magnitude to all-ones (2^(N-1)−1).
  - Sign = a sign.
- Differing effective sign:
  - magnitude = larger − smaller.
  - Sign = sign of the larger operand.
  - Equal magnitudes give +0.
  - ovf=0.
- Final normalization: magnitude 0 forces sign 0.
- Stage 1 registers: a/b' sign bits, magnitude-compare result, op select (add/sub), both magnitudes.
- Stage 2 registers: computed, saturated and normalized c, plus ovf.
- No FSM beyond per-stage valid bits s1_v and s2_v.
- Flow control:
  - s2 loads when !s2_v || out_ready.
  - s1 advances under the same condition.
  - in_ready = !rst && (!s1_v || !s2_v || out_ready). This is a combinational path from out_ready.
- Ordering is strictly preserved; no result is dropped or duplicated.

## Timing
- Reset values (registered on the clk edge while rst=1): s1_v=0, s2_v=0, out_valid=0, c=0, ovf=0.
- in_ready is 0 while rst=1 and 1 on the first cycle after rst deasserts.
- Latency: operands accepted at edge k appear on c/out_valid after edge k+2, i.e. visible in cycle k+2.
- Throughput: 1 result per cycle while out_ready=1.
- Backpressure:
  - With out_ready=0, the pipe holds 2 entries.
  - in_ready drops the cycle both stages are full.
  - c and ovf stay stable while out_valid && !out_ready.
- Simultaneous events:
  - Output consumed and new input accepted in the same cycle while full: both occur with no bubble.
- Reset mid-operation: both stages are flushed. In-flight operands are discarded and never emerge.
- Out-of-range condition: none. Every N-bit input pattern is legal.

## Structure
- Package sm_pkg holds:
  - typedef sm_t = logic [`N-1:0];
  - localparams SM_MAG_MAX = {(`N-1){1'b1}} and SM_NEG_ZERO = {1'b1,{(`N-1){1'b0}}};
  - functions sm_negate(sm_t) and sm_norm_zero(sm_t).
- One sub-module, sm_mag_unit: combinational magnitude add/sub with saturation, used in stage 2. The top holds the pipeline registers and handshake.
- The package is shared with the adder's future pipelined variant.

## Test plan (N=16, F=8)
- Basic subtract: a=0x0300, b=0x0100, out_ready=1 → c=0x0200, ovf=0, out_valid exactly 2 cycles after acceptance.
- Sign crossing: a=0x0100, b=0x0300 → c=0x8200. Separately a=0x8100, b=0x8100 → c=0x0000, never 0x8000.
- Negative-zero input: a=0x8000, b=0x0000 → c=0x0000. Separately a=0x0000, b=0x8000 → c=0x0000.
- Saturation: a=0x7F00, b=0xFF00 → c=0x7FFF, ovf=1. Separately a=0xFF00, b=0x7F00 → c=0xFFFF, ovf=1.
- Backpressure:
  - Stimulus: stream 5 pairs with in_valid=1 and hold out_ready=0 for 4 cycles.
  - Expected: exactly 2 accepted, in_ready=0 from the cycle both stages fill, c stable while stalled.
  - Release: results drain in order with no loss or duplication.
- Reset mid-flight: assert rst for 1 cycle with 2 results in flight → out_valid=0 the next cycle, no stale result emerges, and in_ready=1 the cycle after rst deasserts.
